// File: rtl/rt_ibex_pcs_restore_wb.sv
// Writeback sequencer behind the PCS LIFO: replays a popped context into the
// register file one slot per cycle, sharing the write port with core writeback.
module rt_ibex_pcs_restore_wb #(
  parameter int unsigned NrSavedRegs = 9,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 5,
  parameter logic [NrSavedRegs-1:0][AddrWidth-1:0] SavedRegAddr =
    {5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd7, 5'd6, 5'd5, 5'd1}
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             restore_en_i,
  input  logic [NrSavedRegs*DataWidth-1:0] restore_data_i,
  input  logic                             core_we_i,
  input  logic [AddrWidth-1:0]             core_waddr_i,
  input  logic [DataWidth-1:0]             core_wdata_i,
  output logic                             rf_we_o,
  output logic [AddrWidth-1:0]             rf_waddr_o,
  output logic [DataWidth-1:0]             rf_wdata_o,
  output logic                             stall_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             overlap_err_o
);

  localparam int unsigned CntW = (NrSavedRegs > 1) ? $clog2(NrSavedRegs) : 1;
  localparam logic [CntW-1:0] LastSlot = CntW'(NrSavedRegs - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                                state_q, state_d;
  logic [CntW-1:0]                       cnt_q, cnt_d;
  logic [NrSavedRegs-1:0][DataWidth-1:0] ctx_q;
  logic                                  capture;
  logic [AddrWidth-1:0]                  slot_addr;
  logic [DataWidth-1:0]                  slot_data;

  assign slot_addr = SavedRegAddr[cnt_q];
  assign slot_data = ctx_q[cnt_q];

  // Next state and write-port mux; the core owns the port unless a slot issues
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    done_o     = 1'b0;
    rf_we_o    = core_we_i;
    rf_waddr_o = core_waddr_i;
    rf_wdata_o = core_wdata_i;
    unique case (state_q)
      IDLE: begin
        if (restore_en_i) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!core_we_i) begin
          // x0 slots still consume a cycle but never assert the write enable
          rf_we_o    = (slot_addr != '0);
          rf_waddr_o = slot_addr;
          rf_wdata_o = slot_data;
          if (cnt_q == LastSlot) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o        = (state_q != IDLE);
  assign stall_o       = restore_en_i | (state_q == WRITE);
  assign overlap_err_o = restore_en_i & busy_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        ctx_q <= restore_data_i;
      end
    end
  end

endmodule

// File: tb/tb_rt_ibex_pcs_restore_wb.sv
// Random and directed bench for rt_ibex_pcs_restore_wb: two instances (default
// address map and one with slot 0 mapped to x0) against a queue-based model.
module tb_rt_ibex_pcs_restore_wb;
  localparam int N  = 9;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [N-1:0][AW-1:0] ADDR_A =
    {5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd7, 5'd6, 5'd5, 5'd1};
  localparam logic [N-1:0][AW-1:0] ADDR_B =
    {5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd7, 5'd6, 5'd5, 5'd0};

  logic            clk;
  logic            rst_n;
  logic            restore_en;
  logic [N*DW-1:0] restore_data;
  logic            core_we;
  logic [AW-1:0]   core_waddr;
  logic [DW-1:0]   core_wdata;

  logic          rf_we    [2];
  logic [AW-1:0] rf_waddr [2];
  logic [DW-1:0] rf_wdata [2];
  logic          stall    [2];
  logic          busy     [2];
  logic          done     [2];
  logic          ovl      [2];

  rt_ibex_pcs_restore_wb #(
    .NrSavedRegs(N), .DataWidth(DW), .AddrWidth(AW), .SavedRegAddr(ADDR_A)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .restore_en_i(restore_en), .restore_data_i(restore_data),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .rf_we_o(rf_we[0]), .rf_waddr_o(rf_waddr[0]), .rf_wdata_o(rf_wdata[0]),
    .stall_o(stall[0]), .busy_o(busy[0]), .done_o(done[0]), .overlap_err_o(ovl[0])
  );

  rt_ibex_pcs_restore_wb #(
    .NrSavedRegs(N), .DataWidth(DW), .AddrWidth(AW), .SavedRegAddr(ADDR_B)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .restore_en_i(restore_en), .restore_data_i(restore_data),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .rf_we_o(rf_we[1]), .rf_waddr_o(rf_waddr[1]), .rf_wdata_o(rf_wdata[1]),
    .stall_o(stall[1]), .busy_o(busy[1]), .done_o(done[1]), .overlap_err_o(ovl[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: each pending restore is a queue of {addr,data} writes still owed
  logic [AW+DW-1:0]       mq [2][$];
  bit                     dp [2];
  logic [N-1:0][AW-1:0]   addr_tab [2];

  function automatic bit m_busy(input int k);
    return (mq[k].size() != 0) || dp[k];
  endfunction

  task automatic compare_all();
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    for (int k = 0; k < 2; k++) begin
      if (mq[k].size() != 0 && !core_we) begin
        e_addr = mq[k][0][AW+DW-1:DW];
        e_data = mq[k][0][DW-1:0];
        e_we   = (e_addr != '0);
      end else begin
        e_we   = core_we;
        e_addr = core_waddr;
        e_data = core_wdata;
      end
      check($sformatf("rf_we%0d", k),    64'(rf_we[k]),    64'(e_we));
      check($sformatf("rf_waddr%0d", k), 64'(rf_waddr[k]), 64'(e_addr));
      check($sformatf("rf_wdata%0d", k), 64'(rf_wdata[k]), 64'(e_data));
      check($sformatf("stall%0d", k),    64'(stall[k]),    64'(restore_en || mq[k].size() != 0));
      check($sformatf("busy%0d", k),     64'(busy[k]),     64'(m_busy(k)));
      check($sformatf("done%0d", k),     64'(done[k]),     64'(dp[k]));
      check($sformatf("ovl%0d", k),      64'(ovl[k]),      64'(restore_en && m_busy(k)));
    end
  endtask

  task automatic model_update();
    bit was_busy;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mq[k].delete();
        dp[k] = 1'b0;
      end else begin
        was_busy = m_busy(k);
        if (dp[k]) begin
          dp[k] = 1'b0;
        end else if (mq[k].size() != 0 && !core_we) begin
          void'(mq[k].pop_front());
          if (mq[k].size() == 0) dp[k] = 1'b1;
        end
        if (restore_en && !was_busy) begin
          for (int i = 0; i < N; i++)
            mq[k].push_back({addr_tab[k][i], restore_data[i*DW +: DW]});
        end
      end
    end
  endtask

  // Inputs are set just after the falling edge; outputs sampled 2 ns later
  task automatic step();
    #2;
    compare_all();
    model_update();
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) restore_data[i*DW +: DW] = $urandom;
  endtask

  task automatic idle_inputs();
    restore_en = 1'b0;
    core_we    = 1'b0;
    core_waddr = '0;
    core_wdata = '0;
  endtask

  // Strobe at cycle 0; optional core write and second strobe; returns done latency
  task automatic run_restore(input int core_at, input int ovl_at, output int lat_a, output int lat_b);
    lat_a = -1;
    lat_b = -1;
    for (int c = 0; c < 30; c++) begin
      restore_en = (c == 0) || (c == ovl_at);
      core_we    = (c == core_at);
      core_waddr = 5'd20;
      core_wdata = 32'hBEEF;
      if (c == 0) for (int i = 0; i < N; i++) restore_data[i*DW +: DW] = 32'h100 + i;
      else rand_data();
      #1;
      if (done[0] && lat_a < 0) lat_a = c;
      if (done[1] && lat_b < 0) lat_b = c;
      step();
      if (lat_a >= 0 && lat_b >= 0) break;
    end
    idle_inputs();
  endtask

  int la, lb;

  initial begin
    addr_tab[0] = ADDR_A;
    addr_tab[1] = ADDR_B;
    dp[0] = 1'b0;
    dp[1] = 1'b0;
    rst_n = 1'b0;
    idle_inputs();
    restore_data = '0;

    // Reset with idle passthrough active
    core_we = 1'b1; core_waddr = 5'd3; core_wdata = 32'hAA;
    @(negedge clk);
    step();
    check("rst_rf_we", 64'(rf_we[0]), 64'd1);
    check("rst_waddr", 64'(rf_waddr[0]), 64'd3);
    rst_n = 1'b1;
    step();
    idle_inputs();
    step();

    // Plain restore, then core write at T+3 plus overlapping strobe at T+5
    run_restore(-1, -1, la, lb);
    check("lat_plain_a", 64'(la), 64'd10);
    check("lat_x0slot_b", 64'(lb), 64'd10);
    repeat (2) step();
    run_restore(3, 5, la, lb);
    check("lat_core_ovl_a", 64'(la), 64'd11);
    repeat (2) step();

    // Asynchronous reset mid-WRITE
    restore_en = 1'b1;
    rand_data();
    step();
    restore_en = 1'b0;
    repeat (3) step();
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy[0]), 64'd0);
    check("arst_stall", 64'(stall[0]), 64'd0);
    check("arst_rf_we", 64'(rf_we[0]), 64'd0);
    model_update();
    @(negedge clk);
    rst_n = 1'b1;
    core_we = 1'b1; core_waddr = 5'd9; core_wdata = 32'h1234;
    step();
    idle_inputs();
    run_restore(-1, -1, la, lb);
    check("lat_after_rst", 64'(la), 64'd10);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      restore_en = ($urandom_range(0, 11) == 0);
      core_we    = ($urandom_range(0, 2) == 0);
      core_waddr = AW'($urandom);
      core_wdata = $urandom;
      rand_data();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
